// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Signal bundle between the receive FSM / serial line and the edge/bit sampler.
// The master drives the line and controls; the slave (sampler) returns counters and the voted bit.
interface uart_rx_edge_bit_sampler_if;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       Par_En;
   logic       enable;
   logic       dat_samp_en;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       sampled_bit;
   logic       presc_err;

   modport master (
      output RX_IN, Prescale, Par_En, enable, dat_samp_en,
      input  edge_cnt, bit_cnt, sampled_bit, presc_err
   );

   modport slave (
      input  RX_IN, Prescale, Par_En, enable, dat_samp_en,
      output edge_cnt, bit_cnt, sampled_bit, presc_err
   );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling stage: per-bit edge counter, frame bit counter, majority-of-3 bit sampler.
// All outputs registered (1-cycle latency); no backpressure, the FSM paces it through enable/dat_samp_en.
module uart_rx_edge_bit_sampler (
   input  logic                         clk,
   input  logic                         rst_n,
   uart_rx_edge_bit_sampler_if.slave    sif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       s0_q, s0_d;
   logic       s1_q, s1_d;
   logic       sampled_bit_q, sampled_bit_d;
   logic       presc_err_q, presc_err_d;

   logic [5:0] presc_w;
   logic [5:0] half_w;
   logic       presc_ok_w;
   logic       go_w;
   logic       wrap_w;
   logic [3:0] frame_len_w;
   logic       majority_w;

   assign presc_w     = sif.Prescale;
   assign half_w      = {1'b0, presc_w[5:1]};
   assign presc_ok_w  = (presc_w == 6'd8) || (presc_w == 6'd16) || (presc_w == 6'd32);
   assign frame_len_w = sif.Par_En ? 4'd11 : 4'd10;

   // Counting needs a legal ratio now and a clean registered flag, so recovery takes a cycle.
   assign go_w        = sif.enable && presc_ok_w && !presc_err_q;

   // ">=" rather than "==" so a shrinking Prescale can never let the count run past P-1.
   assign wrap_w      = (cnt_q >= (presc_w - 6'd1));
   assign majority_w  = (s0_q & s1_q) | (s0_q & sif.RX_IN) | (s1_q & sif.RX_IN);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (go_w)  state_d = ST_RUN;
         ST_RUN:  if (!go_w) state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      bit_cnt_d     = bit_cnt_q;
      s0_d          = s0_q;
      s1_d          = s1_q;
      sampled_bit_d = sampled_bit_q;
      presc_err_d   = !presc_ok_w;

      if (go_w) begin
         if (wrap_w) begin
            cnt_d = 6'd0;
            if (bit_cnt_q < frame_len_w) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end else begin
            cnt_d = cnt_q + 6'd1;
         end

         if (sif.dat_samp_en) begin
            if (cnt_q == (half_w - 6'd2)) s0_d = sif.RX_IN;
            if (cnt_q == (half_w - 6'd1)) s1_d = sif.RX_IN;
            if (cnt_q == half_w)          sampled_bit_d = majority_w;
         end
      end else begin
         // Clear path also covers the enable-fall-on-wrap case: clear wins.
         cnt_d         = 6'd0;
         bit_cnt_d     = 4'd0;
         s0_d          = 1'b1;
         s1_d          = 1'b1;
         sampled_bit_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 6'd0;
         bit_cnt_q     <= 4'd0;
         s0_q          <= 1'b1;
         s1_q          <= 1'b1;
         sampled_bit_q <= 1'b1;
         presc_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         s0_q          <= s0_d;
         s1_q          <= s1_d;
         sampled_bit_q <= sampled_bit_d;
         presc_err_q   <= presc_err_d;
      end
   end

   assign sif.edge_cnt    = cnt_q[4:0];
   assign sif.bit_cnt     = bit_cnt_q;
   assign sif.sampled_bit = sampled_bit_q;
   assign sif.presc_err   = presc_err_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations, a negedge monitor pops and compares.
module tb_uart_rx_edge_bit_sampler;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_err;

   uart_rx_edge_bit_sampler_if sif ();

   uart_rx_edge_bit_sampler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   typedef struct {
      int         cyc;
      int         tst;
      int         idx;
      logic [3:0] m;
      logic [4:0] e;
      logic [3:0] b;
      logic       s;
      logic       p;
   } exp_t;

   exp_t sb[$];
   int   tst_id;
   int   push_idx;

   localparam logic [3:0] M_E   = 4'b0001;
   localparam logic [3:0] M_EB  = 4'b0011;
   localparam logic [3:0] M_EBS = 4'b0111;
   localparam logic [3:0] M_ALL = 4'b1111;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic void push(logic [3:0] m, logic [4:0] e, logic [3:0] b, logic s, logic p);
      exp_t x;
      x.cyc = cyc; x.tst = tst_id; x.idx = push_idx;
      x.m = m; x.e = e; x.b = b; x.s = s; x.p = p;
      push_idx++;
      sb.push_back(x);
   endfunction

   // Monitor: the DUT presents its registered state every cycle; compare what is due now.
   initial begin
      exp_t x;
      n_chk = 0;
      n_err = 0;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            n_chk++;
            if (x.cyc != cyc) begin
               n_err++;
               $display("FAIL stale_T%0d_%0d: due cyc=%0d, compared cyc=%0d", x.tst, x.idx, x.cyc, cyc);
            end else if ((x.m[0] && sif.edge_cnt    !== x.e) ||
                         (x.m[1] && sif.bit_cnt     !== x.b) ||
                         (x.m[2] && sif.sampled_bit !== x.s) ||
                         (x.m[3] && sif.presc_err   !== x.p)) begin
               n_err++;
               $display("FAIL chk_T%0d_%0d cyc=%0d: got edge=%0d bit=%0d samp=%b err=%b, want edge=%0d bit=%0d samp=%b err=%b (mask %b)",
                        x.tst, x.idx, cyc, sif.edge_cnt, sif.bit_cnt, sif.sampled_bit, sif.presc_err,
                        x.e, x.b, x.s, x.p, x.m);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_test(input int t);
      tst_id   = t;
      push_idx = 0;
   endtask

   // Drive one bit period cycle by cycle; gm flips RX_IN on selected oversample slots.
   task automatic run_bit(input int p, input logic v, input logic [31:0] gm, input int n,
                          input int b, input logic ev, input bit chk);
      for (int k = 0; k < n; k++) begin
         sif.RX_IN = v ^ gm[k];
         if (k == 0)               push(M_EB, 5'd0, 4'(b), 1'b0, 1'b0);
         if (k == p - 1)           push(M_E, 5'(k), 4'd0, 1'b0, 1'b0);
         if (chk && k == p/2 + 1)  push(M_EBS, 5'(k), 4'(b), ev, 1'b0);
         step();
      end
   endtask

   logic [9:0] f55;

   initial begin
      rst_n           = 1'b0;
      sif.RX_IN       = 1'b1;
      sif.Prescale    = 6'd8;
      sif.Par_En      = 1'b0;
      sif.enable      = 1'b0;
      sif.dat_samp_en = 1'b0;
      tst_id          = 0;
      push_idx        = 0;

      // Reset state
      step(); step();
      new_test(0);
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b0);
      step();
      rst_n = 1'b1;
      step(); step();

      // T1: P=8 full frame of 0x55, start bit first
      new_test(1);
      f55 = {1'b1, 8'h55, 1'b0};
      sif.enable = 1'b1;
      sif.dat_samp_en = 1'b1;
      for (int b = 0; b < 10; b++) run_bit(8, f55[b], 32'h0, 8, b, f55[b], 1'b1);
      push(M_EB, 5'd0, 4'd10, 1'b0, 1'b0);
      sif.enable = 1'b0;
      step();
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b0);
      step();

      // T2: P=16 glitch rejection, then enable dropped at edge 3 of bit 4
      new_test(2);
      sif.Prescale = 6'd16;
      step(); step();
      sif.enable = 1'b1;
      run_bit(16, 1'b1, 32'h0000_0080, 16, 0, 1'b1, 1'b1);
      run_bit(16, 1'b0, 32'h0000_0100, 16, 1, 1'b0, 1'b1);
      run_bit(16, 1'b1, 32'h0000_0000, 16, 2, 1'b1, 1'b1);
      run_bit(16, 1'b1, 32'h0000_0180, 16, 3, 1'b0, 1'b1);
      run_bit(16, 1'b1, 32'h0000_0000, 3,  4, 1'b0, 1'b0);
      push(M_EBS, 5'd3, 4'd4, 1'b0, 1'b0);
      sif.enable = 1'b0;
      step();
      push(M_EBS, 5'd0, 4'd0, 1'b1, 1'b0);
      step();

      // T3: P=32 with parity, enable held past the frame; bit_cnt saturates at 11
      new_test(3);
      sif.Prescale    = 6'd32;
      sif.Par_En      = 1'b1;
      sif.dat_samp_en = 1'b0;
      sif.RX_IN       = 1'b1;
      step(); step();
      sif.enable = 1'b1;
      for (int k = 0; k < 32 * 13; k++) begin
         if ((k % 8) == 0 || (k % 32) == 31)
            push(M_EB, 5'(k % 32), 4'((k / 32) > 11 ? 11 : (k / 32)), 1'b0, 1'b0);
         step();
      end
      sif.enable = 1'b0;
      step();
      push(M_EB, 5'd0, 4'd0, 1'b0, 1'b0);
      sif.Par_En = 1'b0;
      step();

      // T4: illegal Prescale=12 freezes counters; restoring 8 recovers
      new_test(4);
      sif.Prescale = 6'd8;
      step(); step();
      sif.Prescale = 6'd12;
      sif.enable   = 1'b1;
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b0);
      step();
      for (int k = 0; k < 5; k++) begin
         push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b1);
         step();
      end
      sif.Prescale = 6'd8;
      sif.enable   = 1'b0;
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b1);
      step();
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b0);
      sif.enable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         push(M_ALL, 5'(k % 8), 4'(k / 8), 1'b1, 1'b0);
         step();
      end
      sif.enable = 1'b0;
      step(); step();

      // T5: async reset mid-frame at edge 5 of bit 6, P=8
      new_test(5);
      sif.enable      = 1'b1;
      sif.dat_samp_en = 1'b1;
      for (int b = 0; b < 6; b++) run_bit(8, b[0], 32'h0, 8, b, b[0], 1'b1);
      run_bit(8, 1'b0, 32'h0, 4, 6, 1'b0, 1'b0);
      push(M_EBS, 5'd4, 4'd6, 1'b1, 1'b0);
      step();
      #1;
      rst_n = 1'b0;
      push(M_ALL, 5'd0, 4'd0, 1'b1, 1'b0);
      step();
      sif.enable = 1'b0;
      rst_n = 1'b1;
      step(); step(); step();

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
